nx_stream_arbiter: RTL and testbench
====================================

NX_STREAM_ARBITER -- requirements
Module: nx_stream_arbiter

Interface
REQ-001 Parameter STREAMS, default 4: number of inbound streams to merge, 2..8.
REQ-002 Parameter DEPTH, default 2: outbound buffer entries, 2..4.
REQ-003 i_clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-low.
REQ-005 o_idle  output  1  high when the buffer is empty and no inbound valid is asserted.
REQ-006 i_inbound_data  input  STREAMS x MESSAGE_WIDTH  per-stream node_message_t.
REQ-007 i_inbound_valid  input  STREAMS  per-stream valid.
REQ-008 o_inbound_ready  output  STREAMS  per-stream ready, at most one bit high.
REQ-009 o_outbound_dir  output  $clog2(STREAMS)  index of the source stream for the head entry, as a direction_t when STREAMS=4.
REQ-010 o_outbound_data  output  MESSAGE_WIDTH  head entry data.
REQ-011 o_outbound_valid  output  1  head entry valid.
REQ-012 i_outbound_ready  input  1  downstream ready.
REQ-013 o_grant_count  output  STREAMS x 16  per-stream accepted-message counters, present only under NX_STREAM_ARBITER_STATS_EN.

Function
REQ-014 The arbiter shall be round-robin using a pointer rr_ptr, reset to 0.
REQ-015 Winner selection shall pick the first stream with valid high, searching from index rr_ptr upward with modulo-STREAMS wrap.
REQ-016 o_inbound_ready shall be one-hot on the winner when buffer level < DEPTH; otherwise it shall be all-zero.
REQ-017 A transfer on stream s shall occur when valid[s] and ready[s] are both high; this pushes {s, data} into the buffer.
REQ-018 On each transfer, rr_ptr shall load (s+1) mod STREAMS; with no transfer, rr_ptr shall hold.
REQ-019 Buffer behaviour: FIFO of DEPTH entries; head presented on the o_outbound_* outputs; o_outbound_valid = (level != 0).
REQ-020 A pop shall occur when o_outbound_valid and i_outbound_ready are both high.
REQ-021 Latency shall be one cycle: a message accepted in cycle N is presented at the output in cycle N+1 when the buffer was empty.
REQ-022 Push admission shall be decided on the pre-pop level: when level == DEPTH, the block accepts no push even if a pop occurs in the same cycle.
REQ-023 A simultaneous push and pop with level < DEPTH shall leave level unchanged and preserve order.
REQ-024 Read and write pointers shall wrap modulo DEPTH; level arithmetic shall use $clog2(DEPTH+1) bits.
REQ-025 Output data and dir shall be held stable while o_outbound_valid is high and i_outbound_ready is low.
REQ-026 The block shall never drop or duplicate a message.
REQ-027 Any stream holding valid continuously shall be granted within STREAMS transfers.
REQ-028 o_idle shall be combinational from level and i_inbound_valid.

Reset
REQ-029 When i_rst is low, the block shall asynchronously clear level, the read/write pointers, rr_ptr and the grant counters.
REQ-030 Output values while i_rst is low: o_outbound_valid=0, o_inbound_ready=0, o_idle=1 when no inbound valid is high, o_outbound_data=0, o_outbound_dir=0.
REQ-031 A reset asserted mid-operation shall discard all buffered entries; no partial entry shall emerge after reset.
REQ-032 Release from reset shall be synchronous to i_clk; the first transfer is permitted in the first cycle after release.

Configuration
REQ-033 With NX_STREAM_ARBITER_STATS_EN defined: o_grant_count[s] shall increment by 1 on each transfer from stream s and saturate at 16'hFFFF.
REQ-034 Without NX_STREAM_ARBITER_STATS_EN: the o_grant_count port and the counters shall be absent; all other behaviour is identical.

Verification
REQ-035 The bench shall drive a single message on stream 2 with downstream ready; required: o_outbound_valid high one cycle later with dir=2 and matching data; o_idle returns to 1.
REQ-036 The bench shall hold all 4 streams valid continuously with ready=1; required: grant order 0,1,2,3,0,... with one message accepted per cycle.
REQ-037 The bench shall hold downstream ready low with all streams valid (DEPTH=2); required: exactly 2 accepted (streams 0 and 1), then o_inbound_ready=0, and output data held stable.
REQ-038 The bench shall raise ready for one cycle while the buffer is full; required: one pop, no push that cycle, then stream 2 accepted in the next cycle.
REQ-039 The bench shall assert i_rst low with 2 entries buffered; required: o_outbound_valid=0 immediately, and rr_ptr=0 after release, so stream 0 wins first.
REQ-040 With STATS_EN, the bench shall send 70000 messages on stream 1; required: o_grant_count[1]=16'hFFFF and the other counters = 0.

Source files
------------

// File: rtl/nx_stream_arbiter.sv
// Round-robin merge of STREAMS inbound streams into a DEPTH-entry outbound FIFO.
// Optional per-stream accepted-message counters are enabled by NX_STREAM_ARBITER_STATS_EN.
module nx_stream_arbiter #(
    parameter int STREAMS       = 4,
    parameter int DEPTH         = 2,
    parameter int MESSAGE_WIDTH = 32
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    output logic                                    o_idle,
    input  logic [STREAMS-1:0][MESSAGE_WIDTH-1:0]   i_inbound_data,
    input  logic [STREAMS-1:0]                      i_inbound_valid,
    output logic [STREAMS-1:0]                      o_inbound_ready,
    output logic [$clog2(STREAMS)-1:0]              o_outbound_dir,
    output logic [MESSAGE_WIDTH-1:0]                o_outbound_data,
    output logic                                    o_outbound_valid,
`ifdef NX_STREAM_ARBITER_STATS_EN
    output logic [STREAMS-1:0][15:0]                o_grant_count,
`endif
    input  logic                                    i_outbound_ready
);

    localparam int PTR_W   = $clog2(STREAMS);
    localparam int AW      = $clog2(DEPTH);
    localparam int LW      = $clog2(DEPTH + 1);
    localparam int ENTRY_W = PTR_W + MESSAGE_WIDTH;

    logic [PTR_W-1:0]   rrPtr_q, rrPtr_d;
    logic [AW-1:0]      rdPtr_q, rdPtr_d;
    logic [AW-1:0]      wrPtr_q, wrPtr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]   winner;
    logic               anyValid;
    logic               canPush;
    logic               push;
    logic               pop;
    int                 idx;

    function automatic logic [AW-1:0] incPtr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // First valid stream at or after rrPtr_q, wrapping around the stream count.
    always_comb begin
        winner   = '0;
        anyValid = 1'b0;
        idx      = 0;
        for (int k = 0; k < STREAMS; k++) begin
            idx = int'(rrPtr_q) + k;
            if (idx >= STREAMS) idx = idx - STREAMS;
            if (!anyValid && i_inbound_valid[PTR_W'(idx)]) begin
                winner   = PTR_W'(idx);
                anyValid = 1'b1;
            end
        end
    end

    // Admission uses the pre-pop level, so a full buffer never accepts even while draining.
    assign canPush         = (level_q < LW'(DEPTH));
    assign o_inbound_ready = (i_rst && anyValid && canPush) ? (STREAMS'(1) << winner) : '0;
    assign push            = |(i_inbound_valid & o_inbound_ready);
    assign o_outbound_valid = (level_q != '0);
    assign pop             = o_outbound_valid && i_outbound_ready;
    assign o_idle          = (level_q == '0) && !(|i_inbound_valid);
    assign {o_outbound_dir, o_outbound_data} = o_outbound_valid ? mem_q[rdPtr_q] : '0;

    always_comb begin
        rrPtr_d = rrPtr_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        level_d = level_q;
        if (push) begin
            rrPtr_d = (winner == PTR_W'(STREAMS - 1)) ? '0 : winner + 1'b1;
            wrPtr_d = incPtr(wrPtr_q);
        end
        if (pop) rdPtr_d = incPtr(rdPtr_q);
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rrPtr_q <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            level_q <= '0;
        end else begin
            rrPtr_q <= rrPtr_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: entries are only visible while level_q covers them.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wrPtr_q] <= {winner, i_inbound_data[winner]};
    end

`ifdef NX_STREAM_ARBITER_STATS_EN
    logic [STREAMS-1:0][15:0] grantCount_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            grantCount_q <= '0;
        end else if (push && grantCount_q[winner] != 16'hFFFF) begin
            grantCount_q[winner] <= grantCount_q[winner] + 16'd1;
        end
    end

    assign o_grant_count = grantCount_q;
`endif

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Self-checking bench for nx_stream_arbiter (STREAMS=4, DEPTH=2) using a queue-based reference model.
// Build with NX_STREAM_ARBITER_STATS_EN defined to also exercise the grant counters.
module tb_nx_stream_arbiter;

    localparam int STREAMS = 4;
    localparam int DEPTH   = 2;
    localparam int W       = 16;

    logic                        clk = 1'b0;
    logic                        rstN;
    logic [STREAMS-1:0][W-1:0]   inData;
    logic [STREAMS-1:0]          inValid;
    logic [STREAMS-1:0]          inReady;
    logic [1:0]                  outDir;
    logic [W-1:0]                outData;
    logic                        outValid;
    logic                        outReady;
    logic                        idle;
`ifdef NX_STREAM_ARBITER_STATS_EN
    logic [STREAMS-1:0][15:0]    grantCount;
`endif

    typedef struct {
        int         dir;
        logic [W-1:0] data;
    } entry_t;

    entry_t modelQ[$];
    int     rrPtr  = 0;
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    nx_stream_arbiter #(
        .STREAMS(STREAMS),
        .DEPTH(DEPTH),
        .MESSAGE_WIDTH(W)
    ) dut (
        .i_clk(clk),
        .i_rst(rstN),
        .o_idle(idle),
        .i_inbound_data(inData),
        .i_inbound_valid(inValid),
        .o_inbound_ready(inReady),
        .o_outbound_dir(outDir),
        .o_outbound_data(outData),
        .o_outbound_valid(outValid),
`ifdef NX_STREAM_ARBITER_STATS_EN
        .o_grant_count(grantCount),
`endif
        .i_outbound_ready(outReady)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner by the round-robin rule: first valid stream scanning upward from rrPtr.
    function automatic int modelWinner();
        for (int k = 0; k < STREAMS; k++) begin
            int i;
            i = (rrPtr + k) % STREAMS;
            if (inValid[i]) return i;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [STREAMS-1:0] valid, input logic oready);
        inValid = valid;
        for (int s = 0; s < STREAMS; s++) inData[s] = W'($urandom);
        outReady = oready;
    endtask

    task automatic checkOutput(input string tag);
        int w;
        logic [STREAMS-1:0] expReady;
        w = modelWinner();
        expReady = '0;
        if (rstN && w >= 0 && modelQ.size() < DEPTH) expReady[w] = 1'b1;
        checkVal({tag, ".ready"}, 64'(inReady), 64'(expReady));
        checkVal({tag, ".valid"}, 64'(outValid), 64'(modelQ.size() != 0));
        checkVal({tag, ".idle"}, 64'(idle), 64'(modelQ.size() == 0 && inValid == '0));
        if (modelQ.size() != 0) begin
            checkVal({tag, ".data"}, 64'(outData), 64'(modelQ[0].data));
            checkVal({tag, ".dir"}, 64'(outDir), 64'(modelQ[0].dir));
        end else if (!rstN) begin
            checkVal({tag, ".rstData"}, 64'(outData), 64'd0);
            checkVal({tag, ".rstDir"}, 64'(outDir), 64'd0);
        end
    endtask

    task automatic modelAdvance();
        int w;
        bit doPush, doPop;
        w      = modelWinner();
        doPush = (w >= 0) && (modelQ.size() < DEPTH);
        doPop  = (modelQ.size() != 0) && outReady;
        if (doPop) void'(modelQ.pop_front());
        if (doPush) begin
            modelQ.push_back('{w, inData[w]});
            rrPtr = (w + 1) % STREAMS;
        end
    endtask

    task automatic cycleBody(input string tag);
        checkOutput(tag);
        modelAdvance();
        @(posedge clk);
        #1;
    endtask

    task automatic stepCycle(input string tag);
        @(negedge clk);
        cycleBody(tag);
    endtask

    task automatic doReset(input string tag);
        rstN = 1'b0;
        modelQ.delete();
        rrPtr = 0;
        #1;
        checkOutput({tag, ".during"});
`ifdef NX_STREAM_ARBITER_STATS_EN
        checkVal({tag, ".counters"}, 64'(grantCount), 64'd0);
`endif
        @(negedge clk);
        rstN = 1'b1;
        #1;
        cycleBody(tag);
    endtask

    initial begin
        applyStimulus('0, 1'b0);
        doReset("reset");

        // Single message on stream 2.
        applyStimulus(4'b0100, 1'b1);
        stepCycle("single");
        applyStimulus('0, 1'b1);
        @(negedge clk);
        checkVal("single.out.valid", 64'(outValid), 64'd1);
        checkVal("single.out.dir", 64'(outDir), 64'd2);
        cycleBody("singleOut");
        stepCycle("singleIdle");

        // All streams valid, downstream ready: strict rotation.
        doReset("rrReset");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(4'hF, 1'b1);
            @(negedge clk);
            checkVal("rrOrder", 64'(inReady), 64'(1) << (i % 4));
            cycleBody("rr");
        end
        applyStimulus('0, 1'b1);
        stepCycle("drain");

        // Downstream stalled: fills with streams 0 and 1 then stops.
        for (int i = 0; i < 4; i++) begin
            inValid  = 4'hF;
            outReady = 1'b0;
            stepCycle("stall");
        end
        @(negedge clk);
        checkVal("stall.full.ready", 64'(inReady), 64'd0);
        checkVal("stall.head.dir", 64'(outDir), 64'd0);

        // One pop while full: no push that cycle, stream 2 next.
        outReady = 1'b1;
        cycleBody("popFull");
        outReady = 1'b0;
        @(negedge clk);
        checkVal("afterPop.ready", 64'(inReady), 64'b0100);
        cycleBody("afterPop");

        // Reset with two entries buffered; stream 0 must win first afterwards.
        applyStimulus(4'hF, 1'b0);
        doReset("midReset");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(STREAMS'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            stepCycle("random");
        end

`ifdef NX_STREAM_ARBITER_STATS_EN
        applyStimulus('0, 1'b1);
        doReset("statsReset");
        inValid  = 4'b0010;
        outReady = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        for (int s = 0; s < STREAMS; s++) begin
            checkVal("grantCount", 64'(grantCount[s]), (s == 1) ? 64'hFFFF : 64'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
